// File: rtl/counter_pkg.sv
// Shared constants for the step counter family.
package counter_pkg;

  localparam int unsigned MODE_W = 2;

  // Overflow behaviour selector; 2'b11 is treated as MODE_WRAP.
  localparam logic [MODE_W-1:0] MODE_WRAP = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SAT  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_MOD  = 2'b10;

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-value and overflow-event computation for step_counter.
module step_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned STEP_W = 4
) (
  input  logic [WIDTH-1:0]  c,
  input  logic [STEP_W-1:0] step,
  input  logic              up,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  next_c,
  output logic              ovf_event_c
);

  localparam int unsigned W1 = WIDTH + 1;

  logic [WIDTH-1:0] step_ext;
  logic [W1-1:0]    sum;
  logic [W1-1:0]    diff;
  logic [W1-1:0]    lim_ext;
  logic [WIDTH-1:0] mod_up;
  logic [WIDTH-1:0] mod_dn;
  logic             range_err;

  // Arithmetic is done one bit wider so carry/borrow fall out of the top bit.
  assign step_ext  = WIDTH'(step);
  assign sum       = {1'b0, c} + {1'b0, step_ext};
  assign diff      = {1'b0, c} - {1'b0, step_ext};
  assign lim_ext   = {1'b0, limit};
  assign mod_up    = WIDTH'(sum - lim_ext - W1'(1));
  assign mod_dn    = WIDTH'(lim_ext + W1'(1) - ({1'b0, step_ext} - {1'b0, c}));
  assign range_err = (c > limit) || (step_ext > limit);

  // Select next value and event according to the overflow mode.
  always_comb begin
    next_c      = c;
    ovf_event_c = 1'b0;
    case (mode)
      MODE_SAT: begin
        if (up) begin
          ovf_event_c = sum[WIDTH];
          next_c      = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end else begin
          ovf_event_c = diff[WIDTH];
          next_c      = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        end
      end
      MODE_MOD: begin
        if (range_err) begin
          next_c      = '0;
          ovf_event_c = 1'b1;
        end else if (up) begin
          if (sum > lim_ext) begin
            next_c      = mod_up;
            ovf_event_c = 1'b1;
          end else begin
            next_c = sum[WIDTH-1:0];
          end
        end else begin
          if (!diff[WIDTH]) begin
            next_c = diff[WIDTH-1:0];
          end else begin
            next_c      = mod_dn;
            ovf_event_c = 1'b1;
          end
        end
      end
      default: begin
        if (up) begin
          next_c      = sum[WIDTH-1:0];
          ovf_event_c = sum[WIDTH];
        end else begin
          next_c      = diff[WIDTH-1:0];
          ovf_event_c = diff[WIDTH];
        end
      end
    endcase
  end

endmodule

// File: rtl/step_counter.sv
// Up/down counter with programmable step, load and wrap/saturate/modulo overflow.
module step_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up,
  input  logic [STEP_W-1:0] step,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  counter_r,
  output logic              overflow_r,
  output logic              ovf_sticky_r,
  output logic              match_r
);

  logic [WIDTH-1:0] next_c;
  logic             ovf_event_c;
  logic             commit_event_c;

  step_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .c           (counter_r),
    .step        (step),
    .up          (up),
    .mode        (mode),
    .limit       (limit),
    .next_c      (next_c),
    .ovf_event_c (ovf_event_c)
  );

  // An event only counts when the step is actually committed.
  assign commit_event_c = enable && !load && ovf_event_c;

  // Counter, last-update overflow and match registers; load beats enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_r  <= '0;
      overflow_r <= 1'b0;
      match_r    <= 1'b0;
    end else if (load) begin
      counter_r  <= load_value;
      overflow_r <= 1'b0;
      match_r    <= (load_value == limit);
    end else if (enable) begin
      counter_r  <= next_c;
      overflow_r <= ovf_event_c;
      match_r    <= (next_c == limit);
    end
  end

  // Sticky overflow; a new event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_r <= 1'b0;
    end else if (commit_event_c) begin
      ovf_sticky_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench for step_counter (WIDTH=12, STEP_W=4).
module tb_step_counter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        up;
  logic [3:0]  step;
  logic [1:0]  mode;
  logic [11:0] limit;
  logic        load;
  logic [11:0] load_value;
  logic        clr_ovf;
  logic [11:0] counter_r;
  logic        overflow_r;
  logic        ovf_sticky_r;
  logic        match_r;

  typedef struct {
    logic [11:0] cnt;
    logic        ovf;
    logic        stk;
    logic        mt;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  step_counter #(.WIDTH(12), .STEP_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .up           (up),
    .step         (step),
    .mode         (mode),
    .limit        (limit),
    .load         (load),
    .load_value   (load_value),
    .clr_ovf      (clr_ovf),
    .counter_r    (counter_r),
    .overflow_r   (overflow_r),
    .ovf_sticky_r (ovf_sticky_r),
    .match_r      (match_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [11:0] c, input logic o, input logic s,
                      input logic m, input string nm);
    exp_t e;
    e.cnt = c; e.ovf = o; e.stk = s; e.mt = m; e.name = nm;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus, set mid-cycle; the expectation is for after the next edge.
  task automatic cyc(input logic ld, input logic [11:0] lv, input logic en,
                     input logic u, input logic [3:0] st, input logic [1:0] md,
                     input logic [11:0] lim, input logic clr,
                     input logic [11:0] ec, input logic eo, input logic es,
                     input logic em, input string nm);
    @(posedge clk);
    #2;
    load = ld; load_value = lv; enable = en; up = u; step = st;
    mode = md; limit = lim; clr_ovf = clr;
    push(ec, eo, es, em, nm);
  endtask

  // Monitor: outputs are presented every cycle and on the async reset check.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (counter_r !== e.cnt || overflow_r !== e.ovf ||
            ovf_sticky_r !== e.stk || match_r !== e.mt) begin
          n_bad++;
          $display("FAIL %s: got cnt=%h ovf=%b stk=%b mt=%b, want cnt=%h ovf=%b stk=%b mt=%b",
                   e.name, counter_r, overflow_r, ovf_sticky_r, match_r,
                   e.cnt, e.ovf, e.stk, e.mt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; up = 1'b1; step = 4'd0; mode = 2'b00;
    limit = 12'h800; load = 1'b0; load_value = 12'h000; clr_ovf = 1'b0;
    #3;
    push(12'h000, 1'b0, 1'b0, 1'b0, "reset_state");
    -> chk_ev;

    // Release reset and load 0x123.
    @(posedge clk);
    #2;
    rst = 1'b0; load = 1'b1; load_value = 12'h123;
    push(12'h123, 1'b0, 1'b0, 1'b0, "load_123");

    // Reset mid-count with a step in flight clears everything immediately.
    @(posedge clk);
    #2;
    load = 1'b0; enable = 1'b1; up = 1'b1; step = 4'd3;
    #1;
    rst = 1'b1;
    push(12'h000, 1'b0, 1'b0, 1'b0, "async_rst");
    -> chk_ev;

    // First edge after deassertion acts normally.
    @(posedge clk);
    #2;
    rst = 1'b0; enable = 1'b0; load = 1'b1; load_value = 12'h777;
    push(12'h777, 1'b0, 1'b0, 1'b0, "first_edge_load");

    //  ld  lv       en u  st    md     lim      clr  exp_cnt  o  s  m
    cyc(1, 12'hFFF, 0, 1, 4'd0, 2'b00, 12'h800, 0, 12'hFFF, 0, 0, 0, "load_fff");
    cyc(0, 12'h000, 1, 1, 4'd1, 2'b00, 12'h800, 0, 12'h000, 1, 1, 0, "wrap_up");
    cyc(1, 12'h005, 0, 1, 4'd0, 2'b01, 12'h800, 0, 12'h005, 0, 1, 0, "load_005");
    cyc(0, 12'h000, 1, 0, 4'd7, 2'b01, 12'h800, 0, 12'h000, 1, 1, 0, "sat_down");
    cyc(0, 12'h000, 1, 1, 4'd2, 2'b01, 12'h800, 0, 12'h002, 0, 1, 0, "sat_up_after");
    cyc(1, 12'h008, 0, 1, 4'd0, 2'b10, 12'd9,   0, 12'h008, 0, 1, 0, "mod_load8");
    cyc(0, 12'h000, 1, 1, 4'd3, 2'b10, 12'd9,   0, 12'h001, 1, 1, 0, "mod_up_wrap");
    cyc(0, 12'h000, 1, 0, 4'd4, 2'b10, 12'd9,   0, 12'h007, 1, 1, 0, "mod_down_wrap");
    cyc(1, 12'h00C, 1, 1, 4'd1, 2'b10, 12'd9,   0, 12'h00C, 0, 1, 0, "load_beats_en");
    cyc(0, 12'h000, 1, 1, 4'd1, 2'b10, 12'd9,   0, 12'h000, 1, 1, 0, "mod_range_err");
    for (int i = 0; i < 5; i++)
      cyc(0, 12'h5A5, 0, i[0], 4'(i + 3), 2'(i), 12'd9, 0, 12'h000, 1, 1, 0, "hold");
    cyc(1, 12'h0AA, 1, 1, 4'd5, 2'b00, 12'h800, 0, 12'h0AA, 0, 1, 0, "load_0aa");
    cyc(0, 12'h000, 1, 1, 4'd0, 2'b00, 12'h800, 0, 12'h0AA, 0, 1, 0, "step0_wrap");
    cyc(0, 12'h000, 1, 0, 4'd0, 2'b01, 12'h800, 0, 12'h0AA, 0, 1, 0, "step0_sat");
    cyc(1, 12'h005, 0, 1, 4'd0, 2'b10, 12'd9,   0, 12'h005, 0, 1, 0, "load_5");
    cyc(0, 12'h000, 1, 0, 4'd0, 2'b10, 12'd9,   0, 12'h005, 0, 1, 0, "step0_mod");
    cyc(1, 12'h002, 0, 1, 4'd0, 2'b11, 12'h800, 0, 12'h002, 0, 1, 0, "load_2");
    cyc(0, 12'h000, 1, 0, 4'd3, 2'b11, 12'h800, 0, 12'hFFF, 1, 1, 0, "mode11_wrap");
    cyc(0, 12'h000, 1, 1, 4'd1, 2'b00, 12'h800, 1, 12'h000, 1, 1, 0, "clr_race");
    cyc(0, 12'h000, 0, 1, 4'd1, 2'b00, 12'h800, 1, 12'h000, 1, 0, 0, "clr_alone");
    cyc(0, 12'h000, 1, 1, 4'd1, 2'b00, 12'h800, 0, 12'h001, 0, 0, 0, "step_no_evt");
    cyc(1, 12'hFFE, 0, 1, 4'd0, 2'b01, 12'h800, 0, 12'hFFE, 0, 0, 0, "load_ffe");
    cyc(0, 12'h000, 1, 1, 4'd5, 2'b01, 12'h800, 0, 12'hFFF, 1, 1, 0, "sat_up");
    cyc(1, 12'h010, 0, 1, 4'd0, 2'b00, 12'h800, 1, 12'h010, 0, 0, 0, "load_with_clr");
    cyc(1, 12'h00E, 0, 1, 4'd0, 2'b00, 12'h010, 0, 12'h00E, 0, 0, 0, "load_00e");
    cyc(0, 12'h000, 1, 1, 4'd2, 2'b00, 12'h010, 0, 12'h010, 0, 0, 1, "match_set");
    cyc(0, 12'h000, 0, 1, 4'd2, 2'b00, 12'h011, 0, 12'h010, 0, 0, 1, "match_hold");
    cyc(0, 12'h000, 1, 1, 4'd2, 2'b00, 12'h011, 0, 12'h012, 0, 0, 0, "match_clear");
    cyc(1, 12'h011, 0, 1, 4'd0, 2'b00, 12'h011, 0, 12'h011, 0, 0, 1, "load_match");
    cyc(1, 12'h002, 0, 1, 4'd0, 2'b10, 12'd3,   0, 12'h002, 0, 0, 0, "load_2_lim3");
    cyc(0, 12'h000, 1, 1, 4'd4, 2'b10, 12'd3,   0, 12'h000, 1, 1, 0, "mod_step_gt_lim");
    cyc(1, 12'h001, 0, 1, 4'd0, 2'b10, 12'd3,   0, 12'h001, 0, 1, 0, "load_1_lim3");
    cyc(0, 12'h000, 1, 1, 4'd2, 2'b10, 12'd3,   0, 12'h003, 0, 1, 1, "mod_up_to_lim");
    cyc(0, 12'h000, 1, 0, 4'd3, 2'b10, 12'd3,   0, 12'h000, 0, 1, 0, "mod_down_exact");
    cyc(0, 12'h000, 1, 0, 4'd1, 2'b10, 12'd3,   0, 12'h003, 1, 1, 1, "mod_down_under");
    cyc(1, 12'hFF5, 0, 1, 4'd0, 2'b00, 12'h800, 0, 12'hFF5, 0, 1, 0, "load_ff5");
    cyc(0, 12'h000, 1, 1, 4'hF, 2'b00, 12'h800, 0, 12'h004, 1, 1, 0, "max_step_wrap");

    @(posedge clk);
    #2;
    enable = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
